// File: rtl/conv_maxpool.sv
// 2x2 stride-2 signed max pooling (with optional ReLU) over a raster stream of
// convolution results; emits pooled values tagged with their pooled row/column.
module conv_maxpool #(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_SIZE  = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int OUT_DIM     = IMAGE_SIZE - KERNEL_SIZE + 1,
  parameter int POOL_DIM    = OUT_DIM / 2,
  parameter int RELU_EN     = 1,
  parameter int CNT_W       = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]             out_row,
  output logic [CNT_W-1:0]             out_col,
  output logic                         frame_done
);

  localparam logic [CNT_W-1:0] LAST      = CNT_W'(OUT_DIM - 1);
  localparam logic [CNT_W-1:0] PAIR_LIM  = CNT_W'(2 * POOL_DIM);
  localparam logic [CNT_W-1:0] POOL_LAST = CNT_W'(POOL_DIM - 1);

  logic [CNT_W-1:0]             col, row;
  logic [CNT_W-1:0]             half_row, half_col;
  logic [CNT_W-2:0]             lb_idx;
  logic signed [DATA_WIDTH-1:0] pair_q, x, hmax, lb_rd, vmax;
  logic signed [DATA_WIDTH-1:0] linebuf [POOL_DIM];
  logic                         in_window, lb_write, emit;

  assign lb_idx   = col[CNT_W-1:1];
  assign half_row = {1'b0, row[CNT_W-1:1]};
  assign half_col = {1'b0, col[CNT_W-1:1]};

  // The trailing row/column of an odd-sized map is counted but never pooled.
  assign in_window = (row < PAIR_LIM) && (col < PAIR_LIM);
  assign lb_write  = in_valid && in_window && !row[0] && col[0];
  assign emit      = in_valid && in_window &&  row[0] && col[0];

  always_comb begin
    x = in_data;
    if (RELU_EN != 0 && in_data < 0) x = '0;
    hmax  = (x > pair_q) ? x : pair_q;
    lb_rd = linebuf[lb_idx];
    vmax  = (lb_rd > hmax) ? lb_rd : hmax;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      pair_q     <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit && (half_row == POOL_LAST) && (half_col == POOL_LAST);
      if (in_valid) begin
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) pair_q <= x;
      end
      if (emit) begin
        out_data <= vmax;
        out_row  <= half_row;
        out_col  <= half_col;
      end
    end
  end

  // NOTE: the line buffer has no reset; every entry is written on an even row
  // before the following odd row reads it, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (lb_write) linebuf[lb_idx] <= hmax;
  end

endmodule

// File: tb/tb_conv_maxpool.sv
// Scoreboard bench for conv_maxpool: two instances (ReLU on / off) share one
// input stream; a reference pooling model predicts every tagged output.
module tb_conv_maxpool;

  localparam int OD = 24;
  localparam int PD = 12;

  typedef struct {
    int data;
    int row;
    int col;
    bit done;
    int due;
  } exp_t;

  typedef struct {
    string name;
    int fill;
    int a, b, c, d;
    int exp_relu;
    int exp_raw;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic signed [15:0] in_data;

  logic               ov [2];
  logic signed [15:0] od [2];
  logic [4:0]         orow [2];
  logic [4:0]         ocol [2];
  logic               ofd [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   img [OD][OD];
  exp_t sb [2][$];
  int   done_cnt [2];
  int   out00 [2];
  int   out_last [2];
  int   out34 [2];

  always #5 clk = ~clk;

  // Index 0: ReLU bypassed; index 1: ReLU enabled.
  conv_maxpool #(.RELU_EN(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_data(od[0]), .out_row(orow[0]), .out_col(ocol[0]),
    .frame_done(ofd[0]));

  conv_maxpool #(.RELU_EN(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_data(od[1]), .out_row(orow[1]), .out_col(ocol[1]),
    .frame_done(ofd[1]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int relu(input int en, input int v);
    return (en != 0 && v < 0) ? 0 : v;
  endfunction

  function automatic int pool_exp(input int en, input int r, input int c);
    int m;
    m = relu(en, img[r-1][c-1]);
    if (relu(en, img[r-1][c]) > m) m = relu(en, img[r-1][c]);
    if (relu(en, img[r][c-1]) > m) m = relu(en, img[r][c-1]);
    if (relu(en, img[r][c])   > m) m = relu(en, img[r][c]);
    return m;
  endfunction

  task automatic mon(input int i);
    exp_t e;
    if (ov[i]) begin
      if (sb[i].size() == 0) begin
        check($sformatf("unexpected_out%0d", i), 1, 0);
      end else begin
        e = sb[i].pop_front();
        check($sformatf("data%0d", i), int'(od[i]), e.data);
        check($sformatf("row%0d", i), int'(orow[i]), e.row);
        check($sformatf("col%0d", i), int'(ocol[i]), e.col);
        check($sformatf("done%0d", i), int'(ofd[i]), int'(e.done));
        check($sformatf("latency%0d", i), cyc, e.due);
      end
      if (ofd[i]) done_cnt[i]++;
      if (orow[i] == 0 && ocol[i] == 0) out00[i] = int'(od[i]);
      if (orow[i] == 5'(PD-1) && ocol[i] == 5'(PD-1)) out_last[i] = int'(od[i]);
      if (orow[i] == 3 && ocol[i] == 4) out34[i] = int'(od[i]);
    end else begin
      if (ofd[i]) check($sformatf("done_without_valid%0d", i), 1, 0);
      if (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
        check($sformatf("missing_out%0d", i), 0, 1);
        void'(sb[i].pop_front());
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    mon(0);
    mon(1);
  end

  task automatic drive(input logic v, input int d);
    @(negedge clk);
    in_valid = v;
    in_data  = 16'(d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0);
  endtask

  task automatic send_frame(input int nbeats, input bit gap);
    int n = 0;
    exp_t e;
    for (int r = 0; r < OD; r++) begin
      for (int c = 0; c < OD; c++) begin
        if (n == nbeats) return;
        for (int k = 0; gap && k < 6 && $urandom_range(0, 1) == 1; k++) drive(1'b0, 0);
        drive(1'b1, img[r][c]);
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          for (int i = 0; i < 2; i++) begin
            e.data = pool_exp(i, r, c);
            e.row  = r / 2;
            e.col  = c / 2;
            e.done = (r / 2 == PD - 1) && (c / 2 == PD - 1);
            e.due  = cyc + 1;
            sb[i].push_back(e);
          end
        end
        n++;
      end
    end
  endtask

  task automatic fill_ramp(input int offset);
    for (int r = 0; r < OD; r++)
      for (int c = 0; c < OD; c++) img[r][c] = r * OD + c + offset;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_valid"}, int'(ov[i]), 0);
      check({tag, "_data"},  int'(od[i]), 0);
      check({tag, "_row"},   int'(orow[i]), 0);
      check({tag, "_col"},   int'(ocol[i]), 0);
      check({tag, "_done"},  int'(ofd[i]), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    int   d0;
    vecs[0] = '{"max_q00", 0, 32767, 0, 0, 0, 32767, 32767};
    vecs[1] = '{"max_q01", 0, 0, 32767, 0, 0, 32767, 32767};
    vecs[2] = '{"max_q10", 0, 0, 0, 32767, 0, 32767, 32767};
    vecs[3] = '{"max_q11", 0, 0, 0, 0, 32767, 32767, 32767};
    vecs[4] = '{"signed_cmp", 0, -3, -7, -1, -9, 0, -1};
    vecs[5] = '{"all_neg5", -5, -5, -5, -5, -5, 0, -5};
    vecs[6] = '{"tie", 0, 7, 7, 7, 7, 7, 7};
    vecs[7] = '{"most_neg", 0, -32768, -32768, -32768, -32767, 0, -32767};

    done_cnt = '{0, 0};
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    reset = 1'b1;

    // Continuous ramp frame.
    fill_ramp(0);
    d0 = done_cnt[1];
    send_frame(OD * OD, 1'b0);
    idle(3);
    check("ramp_first", out00[1], 25);
    check("ramp_last", out_last[1], 575);
    check("ramp_done_cnt", done_cnt[1] - d0, 1);

    // Same frame with random in_valid gaps.
    d0 = done_cnt[1];
    send_frame(OD * OD, 1'b1);
    idle(3);
    check("gap_done_cnt", done_cnt[1] - d0, 1);

    // Abort a frame with reset, then a clean frame.
    fill_ramp(500);
    send_frame(300, 1'b0);
    idle(2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    reset = 1'b1;
    fill_ramp(0);
    send_frame(OD * OD, 1'b0);
    idle(3);
    check("post_rst_first", out00[1], 25);
    check("post_rst_last", out_last[1], 575);

    // Back-to-back frames, no idle cycle between them.
    d0 = done_cnt[0];
    fill_ramp(0);
    send_frame(OD * OD, 1'b0);
    fill_ramp(1000);
    send_frame(OD * OD, 1'b0);
    idle(3);
    check("b2b_done_cnt", done_cnt[0] - d0, 2);
    check("b2b_first", out00[0], 1025);
    check("b2b_last", out_last[0], 1575);

    // Window (3,4) patterns: rows 6..7, cols 8..9.
    for (int v = 0; v < 8; v++) begin
      for (int r = 0; r < OD; r++)
        for (int c = 0; c < OD; c++) img[r][c] = vecs[v].fill;
      img[6][8] = vecs[v].a;
      img[6][9] = vecs[v].b;
      img[7][8] = vecs[v].c;
      img[7][9] = vecs[v].d;
      out34 = '{99999, 99999};
      send_frame(OD * OD, 1'b0);
      idle(3);
      check({vecs[v].name, "_relu"}, out34[1], vecs[v].exp_relu);
      check({vecs[v].name, "_raw"}, out34[0], vecs[v].exp_raw);
    end

    idle(3);
    check("sb_drain0", sb[0].size(), 0);
    check("sb_drain1", sb[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
